m65c02_int_ctrl: RTL and testbench

M65C02_INT_CTRL -- requirements
Module: m65c02_int_ctrl

---
 rtl/m65c02_int_ctrl.sv | 144 ++++++++++++++
 tb/tb_m65c02_int_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/m65c02_int_ctrl.sv
// Interrupt controller for a 65C02 core: resolves ABRT, NMI, maskable requests, BRK and COP into one vector.
// Latency: 1 Clk from level input to Int, 2 Clk for edge inputs; outputs frozen from LE_Int until the vector pull.
module m65c02_int_ctrl #(
    parameter int            pN        = 8,
    parameter logic [pN-1:0] pEdge     = '0,
    parameter logic [15:0]   pVec_Base = 16'hFFE0,
    parameter logic [15:0]   pVec_RST  = 16'hFFFC,
    parameter logic [15:0]   pVec_ABRT = 16'hFFF8,
    parameter logic [15:0]   pVec_NMI  = 16'hFFFA,
    parameter logic [15:0]   pVec_BRK  = 16'hFFFE,
    parameter logic [15:0]   pVec_COP  = 16'hFFF4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Rdy,
    input  logic          ABRT,
    input  logic          NMI,
    input  logic          BRK,
    input  logic          COP,
    input  logic [pN-1:0] RQST,
    input  logic          IRQ_Msk,
    input  logic          Msk_WE,
    input  logic [pN-1:0] Msk_WD,
    output logic [pN-1:0] Msk,
    input  logic          LE_Int,
    input  logic          VP,
    output logic          Int,
    output logic [15:0]   Vector,
    output logic [4:0]    Src,
    output logic [pN-1:0] Pend
);
    localparam logic [4:0] SRC_NONE = 5'd0;
    localparam logic [4:0] SRC_ABRT = 5'd1;
    localparam logic [4:0] SRC_NMI  = 5'd2;
    localparam logic [4:0] SRC_BRK  = 5'd3;
    localparam logic [4:0] SRC_COP  = 5'd4;

    logic          nmi_q;
    logic          vp_q;
    logic [pN-1:0] rqst_q;
    logic          nmi_pend;
    logic [pN-1:0] edge_pend;
    logic          hold;

    logic          re_nmi;
    logic          re_vp;
    logic          ack;
    logic [pN-1:0] re_rqst;
    logic [pN-1:0] clr;
    logic [pN-1:0] elig;

    logic          nxt_int;
    logic [15:0]   nxt_vec;
    logic [4:0]    nxt_src;

    assign re_nmi  = NMI & ~nmi_q;
    assign re_vp   = VP & ~vp_q;
    assign re_rqst = RQST & ~rqst_q;
    assign ack     = Rdy & re_vp & hold;

    // Acknowledge only retires the source that was latched when Hold went high.
    always_comb begin
        for (int i = 0; i < pN; i++) begin
            clr[i]  = ack && (Src == 5'(16 + i));
            Pend[i] = pEdge[i] ? edge_pend[i] : RQST[i];
        end
    end

    assign elig = Pend & ~Msk & {pN{~IRQ_Msk}};

    // Later assignments override earlier ones, so sources are listed lowest priority first.
    always_comb begin
        nxt_int = 1'b0;
        nxt_vec = pVec_RST;
        nxt_src = SRC_NONE;
        if (COP) begin
            nxt_int = 1'b1;
            nxt_vec = pVec_COP;
            nxt_src = SRC_COP;
        end
        if (BRK) begin
            nxt_int = 1'b1;
            nxt_vec = pVec_BRK;
            nxt_src = SRC_BRK;
        end
        for (int i = 0; i < pN; i++) begin
            if (elig[i]) begin
                nxt_int = 1'b1;
                nxt_vec = pVec_Base + 16'(2 * i);
                nxt_src = 5'(16 + i);
            end
        end
        if (nmi_pend) begin
            nxt_int = 1'b1;
            nxt_vec = pVec_NMI;
            nxt_src = SRC_NMI;
        end
        if (ABRT) begin
            nxt_int = 1'b1;
            nxt_vec = pVec_ABRT;
            nxt_src = SRC_ABRT;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            nmi_q     <= 1'b0;
            vp_q      <= 1'b0;
            rqst_q    <= '0;
            nmi_pend  <= 1'b0;
            edge_pend <= '0;
            Msk       <= '1;
            hold      <= 1'b1;
            Int       <= 1'b0;
            Vector    <= pVec_RST;
            Src       <= SRC_NONE;
        end else begin
            nmi_q  <= NMI;
            vp_q   <= VP;
            rqst_q <= RQST;

            if (re_nmi)
                nmi_pend <= 1'b1;
            else if (ack && (Src == SRC_NMI))
                nmi_pend <= 1'b0;

            edge_pend <= pEdge & ((edge_pend & ~clr) | re_rqst);

            if (Msk_WE)
                Msk <= Msk_WD;

            if (Rdy && LE_Int)
                hold <= 1'b1;
            else if (Rdy && re_vp)
                hold <= 1'b0;

            if (!hold) begin
                Int    <= nxt_int;
                Vector <= nxt_vec;
                Src    <= nxt_src;
            end
        end
    end
endmodule

// File: tb/tb_m65c02_int_ctrl.sv
// Bench for m65c02_int_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a priority-list model of the controller.
module tb_m65c02_int_ctrl;
    localparam int         N    = 8;
    localparam logic [7:0] EDGE = 8'h84;

    logic          Clk = 1'b0;
    logic          Rst, Rdy, ABRT, NMI, BRK, COP, IRQ_Msk, Msk_WE, LE_Int, VP;
    logic [N-1:0]  RQST, Msk_WD, Msk, Pend;
    logic          Int;
    logic [15:0]   Vector;
    logic [4:0]    Src;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    m65c02_int_ctrl #(.pN(N), .pEdge(EDGE)) dut (
        .Clk(Clk), .Rst(Rst), .Rdy(Rdy), .ABRT(ABRT), .NMI(NMI), .BRK(BRK), .COP(COP),
        .RQST(RQST), .IRQ_Msk(IRQ_Msk), .Msk_WE(Msk_WE), .Msk_WD(Msk_WD), .Msk(Msk),
        .LE_Int(LE_Int), .VP(VP), .Int(Int), .Vector(Vector), .Src(Src), .Pend(Pend)
    );

    always #5 Clk = ~Clk;

    // Model state
    bit         m_hold, m_int, m_nmi, p_nmi, p_vp;
    bit [7:0]   m_ep, m_msk, p_rqst;
    bit [15:0]  m_vec;
    bit [4:0]   m_src;

    function automatic logic [15:0] vec_of(input logic [4:0] s);
        case (s)
            5'd1: return 16'hFFF8;
            5'd2: return 16'hFFFA;
            5'd3: return 16'hFFFE;
            5'd4: return 16'hFFF4;
            default: return (s >= 5'd16) ? 16'hFFE0 + 16'(2 * (int'(s) - 16)) : 16'hFFFC;
        endcase
    endfunction

    function automatic logic [7:0] model_pend();
        logic [7:0] p;
        for (int i = 0; i < N; i++) p[i] = EDGE[i] ? m_ep[i] : RQST[i];
        return p;
    endfunction

    // First match scanning from highest priority downwards.
    function automatic logic [4:0] winner();
        logic [7:0] p;
        p = model_pend();
        if (ABRT) return 5'd1;
        if (m_nmi) return 5'd2;
        for (int i = N - 1; i >= 0; i--)
            if (p[i] && !m_msk[i] && !IRQ_Msk) return 5'(16 + i);
        if (BRK) return 5'd3;
        if (COP) return 5'd4;
        return 5'd0;
    endfunction

    always @(posedge Clk) begin
        logic [4:0] w;
        logic       rv, ack;
        if (Rst) begin
            m_hold = 1; m_int = 0; m_vec = 16'hFFFC; m_src = 0;
            m_nmi = 0; m_ep = 0; m_msk = 8'hFF; p_nmi = 0; p_vp = 0; p_rqst = 0;
        end else begin
            rv  = VP && !p_vp;
            ack = Rdy && rv && m_hold;
            w   = winner();
            if (ack && m_src == 5'd2) m_nmi = 0;
            if (NMI && !p_nmi) m_nmi = 1;
            for (int i = 0; i < N; i++) begin
                if (EDGE[i]) begin
                    if (ack && m_src == 5'(16 + i)) m_ep[i] = 0;
                    if (RQST[i] && !p_rqst[i]) m_ep[i] = 1;
                end
            end
            if (!m_hold) begin
                m_src = w;
                m_vec = vec_of(w);
                m_int = (w != 0);
            end
            if (Rdy && LE_Int) m_hold = 1;
            else if (Rdy && rv) m_hold = 0;
            if (Msk_WE) m_msk = Msk_WD;
            p_nmi = NMI; p_vp = VP; p_rqst = RQST;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("model_int", 32'(Int), 32'(m_int));
            check("model_vector", 32'(Vector), 32'(m_vec));
            check("model_src", 32'(Src), 32'(m_src));
            check("model_msk", 32'(Msk), 32'(m_msk));
            check("model_pend", 32'(Pend), 32'(model_pend()));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic outs(input string name, input logic i, input logic [15:0] v, input logic [4:0] s);
        check({name, "_int"}, 32'(Int), 32'(i));
        check({name, "_vector"}, 32'(Vector), 32'(v));
        check({name, "_src"}, 32'(Src), 32'(s));
    endtask

    task automatic serve();
        LE_Int = 1; step(1);
        LE_Int = 0; VP = 1; step(1);
        VP = 0; step(1);
    endtask

    initial begin
        Rst = 1; Rdy = 1; ABRT = 0; NMI = 0; BRK = 0; COP = 0; IRQ_Msk = 0;
        Msk_WE = 0; Msk_WD = 0; LE_Int = 0; VP = 0; RQST = 0;
        step(1);
        chk_en = 1;
        step(1);
        outs("reset", 0, 16'hFFFC, 0);
        check("reset_msk", 32'(Msk), 32'hFF);
        check("reset_pend", 32'(Pend), 0);

        // Hold stays set after reset until the reset vector pull
        Rst = 0; BRK = 1; step(2);
        outs("hold_after_reset", 0, 16'hFFFC, 0);
        BRK = 0; VP = 1; step(1);
        VP = 0; step(1);
        outs("after_reset_vp", 0, 16'hFFFC, 0);
        BRK = 1; step(1);
        outs("brk", 1, 16'hFFFE, 3);
        COP = 1; step(1);
        outs("brk_over_cop", 1, 16'hFFFE, 3);
        BRK = 0; step(1);
        outs("cop", 1, 16'hFFF4, 4);
        COP = 0; step(1);

        // Level channels 3 and 5, then global mask
        Msk_WE = 1; Msk_WD = 8'h00; step(1);
        Msk_WE = 0;
        check("msk_write", 32'(Msk), 0);
        RQST = 8'h28; step(1);
        outs("level_3_5", 1, 16'hFFEA, 21);
        IRQ_Msk = 1; step(1);
        outs("irq_msk", 0, 16'hFFFC, 0);
        IRQ_Msk = 0; RQST = 0; step(1);

        // Edge channel 2, latched then acknowledged
        RQST = 8'h04; step(1);
        RQST = 0;
        check("edge2_pend", 32'(Pend), 32'h04);
        step(1);
        outs("edge2", 1, 16'hFFE4, 18);
        LE_Int = 1; step(1);
        LE_Int = 0; RQST = 8'h20; step(1);
        outs("edge2_frozen", 1, 16'hFFE4, 18);
        VP = 1; step(1);
        check("edge2_ack_pend", 32'(Pend), 32'h20);
        VP = 0; step(1);
        outs("after_ack", 1, 16'hFFEA, 21);
        RQST = 0; step(1);

        // NMI edge while serving RQST[0]
        RQST = 8'h01; step(1);
        outs("rqst0", 1, 16'hFFE0, 16);
        LE_Int = 1; step(1);
        LE_Int = 0; NMI = 1; step(1);
        NMI = 0; RQST = 0; step(2);
        outs("nmi_while_held", 1, 16'hFFE0, 16);
        VP = 1; step(1);
        VP = 0; step(1);
        outs("nmi_next", 1, 16'hFFFA, 2);
        serve();
        outs("nmi_acked", 0, 16'hFFFC, 0);

        // All traps at once; NMI must survive ABRT
        ABRT = 1; NMI = 1; BRK = 1; COP = 1; step(1);
        outs("abrt_top", 1, 16'hFFF8, 1);
        ABRT = 0; NMI = 0; BRK = 0; COP = 0; step(1);
        outs("nmi_kept", 1, 16'hFFFA, 2);
        serve();

        // Mask write coincident with an edge request
        Msk_WE = 1; Msk_WD = 8'h04; RQST = 8'h04; step(1);
        Msk_WE = 0; RQST = 0;
        check("mskwe_pend", 32'(Pend), 32'h04);
        step(1);
        outs("masked_edge", 0, 16'hFFFC, 0);
        Msk_WE = 1; Msk_WD = 8'h00; step(1);
        Msk_WE = 0; step(1);
        outs("unmasked_edge", 1, 16'hFFE4, 18);
        RQST = 8'h80; step(1);
        RQST = 0; step(1);
        outs("edge7_over_2", 1, 16'hFFEE, 23);

        // Reset mid-operation drops pending edges
        LE_Int = 1; step(1);
        LE_Int = 0; Rst = 1; step(1);
        Rst = 0;
        outs("mid_reset", 0, 16'hFFFC, 0);
        check("mid_reset_pend", 32'(Pend), 0);
        check("mid_reset_msk", 32'(Msk), 32'hFF);
        VP = 1; step(1);
        VP = 0; step(1);

        for (int c = 0; c < 4000; c++) begin
            Rst     = ($urandom_range(0, 399) == 0);
            Rdy     = ($urandom_range(0, 3) != 0);
            ABRT    = ($urandom_range(0, 15) == 0);
            NMI     = ($urandom_range(0, 5) == 0);
            BRK     = ($urandom_range(0, 9) == 0);
            COP     = ($urandom_range(0, 9) == 0);
            IRQ_Msk = ($urandom_range(0, 4) == 0);
            RQST    = RQST ^ 8'($urandom & $urandom & $urandom);
            Msk_WE  = ($urandom_range(0, 19) == 0);
            Msk_WD  = 8'($urandom);
            LE_Int  = ($urandom_range(0, 5) == 0);
            VP      = ($urandom_range(0, 3) == 0);
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
